mipsfpga_spi_master: RTL and testbench
======================================

MIPSFPGA_SPI_MASTER -- requirements
Module: mipsfpga_spi_master

Interface
REQ-001 Parameter DATA_W, default 8: bits per frame; legal range 2..32.
REQ-002 Parameter DIV_W, default 16: width of the half_period input.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge; no logic is clocked on sck.
REQ-004 Port resetn, input, 1: synchronous, active-low reset.
REQ-005 Port tx_data, input, DATA_W: frame to transmit; sampled on accept.
REQ-006 Port send, input, 1: start request; accepted only when busy=0.
REQ-007 Port cpol, input, 1: SCK idle level; sampled on accept.
REQ-008 Port cpha, input, 1: clock phase; sampled on accept.
REQ-009 Port lsb_first, input, 1: 1 sends and receives LSB first, 0 sends and receives MSB first; sampled on accept.
REQ-010 Port half_period, input, DIV_W: clk cycles per SCK half-period (H); sampled on accept; value 0 is treated as 1.
REQ-011 Port sdi, input, 1: serial data in.
REQ-012 Port sck, output, 1: serial clock.
REQ-013 Port sdo, output, 1: serial data out.
REQ-014 Port cs_n, output, 1: active-low chip select.
REQ-015 Port busy, output, 1: high from the cycle after accept until the done cycle; low in the done cycle.
REQ-016 Port done, output, 1: one-cycle completion pulse.
REQ-017 Port rx_data, output, DATA_W: last received frame; holds until the next done.

Function
REQ-018 The block SHALL use the states IDLE, LEAD, XFER and TRAIL.
REQ-019 Accept: send=1 with busy=0 in cycle T0 SHALL latch tx_data, cpol, cpha, lsb_first and H, and enter LEAD with cs_n=0 and busy=1 at T0+1.
REQ-020 send while busy=1 SHALL be ignored and SHALL NOT alter the frame in progress.
REQ-021 A half-period tick SHALL occur every H clk cycles; the counter SHALL restart at each state entry.
REQ-022 LEAD SHALL last H cycles with sck=cpol; with cpha=0 the first bit SHALL be on sdo from T0+1.
REQ-023 XFER SHALL last 2*DATA_W*H cycles, and sck SHALL toggle on every tick, giving DATA_W full SCK periods.
REQ-024 With cpha=0, sdi SHALL be sampled on each leading edge and sdo SHALL shift on each trailing edge except the last.
REQ-025 With cpha=1, sdo SHALL shift on each leading edge, with the first bit driven on the first leading edge, and sdi SHALL be sampled on each trailing edge.
REQ-026 At the end of XFER, sck SHALL equal cpol, and TRAIL SHALL then last H cycles with cs_n=0.
REQ-027 At T0+1+(2*DATA_W+2)*H the block SHALL drive done=1, update rx_data, drive cs_n=1 and busy=0, and return to IDLE.
REQ-028 send=1 in the done cycle SHALL be accepted (back-to-back transfer), so cs_n is high for exactly 1 cycle.
REQ-029 In IDLE, sck SHALL hold the last latched cpol, sdo SHALL hold its last value, and cs_n SHALL be 1.
REQ-030 The bit counter SHALL count 0..DATA_W-1 and SHALL NOT wrap within a frame; the tick counter width SHALL be DIV_W.

Reset
REQ-031 With resetn=0 at a rising clk edge, the next cycle SHALL show: state IDLE, sck=0, sdo=0, cs_n=1, busy=0, done=0, rx_data=0, latched cpol=0, and counters 0.
REQ-032 Reset mid-transfer SHALL abort the frame immediately with no done pulse; send during reset SHALL be ignored.

Structure
REQ-033 A shared package mipsfpga_spi_pkg SHALL hold the state enum typedef and the mode struct typedef (cpol, cpha, lsb_first).
REQ-034 Half-period tick generation SHALL be a sub-module mipsfpga_spi_clkgen (inputs: enable, restart, H; output: tick).

Verification
REQ-035 The bench SHALL cover mode 0, DATA_W=8, H=2, tx_data=0xA5, sdi looped to sdo, send at T0 -> cs_n falls at T0+1, 8 sck rising edges, done at T0+37, rx_data=0xA5.
REQ-036 The bench SHALL cover mode 3 (cpol=1, cpha=1), H=1, tx_data=0x3C, sdi tied 1 -> sck idles high after the first frame, sdo changes only on falling sck, rx_data=0xFF, done at T0+19.
REQ-037 The bench SHALL cover lsb_first=1, tx_data=0x01, mode 0 -> the first sdo bit is 1 and the remaining 7 bits are 0.
REQ-038 The bench SHALL cover send pulsed with tx_data=0xFF mid-frame of a 0x00 transfer -> it is ignored, the sdo frame stays all 0, and there is exactly one done.
REQ-039 The bench SHALL cover two frames with send held high, H=1 -> the second cs_n fall occurs 1 cycle after the first done, and there are two done pulses 19 cycles apart.
REQ-040 The bench SHALL cover resetn=0 during XFER bit 4 -> the next cycle shows cs_n=1, sck=0, busy=0, no done pulse, rx_data=0.

Source files
------------

// File: rtl/mipsfpga_spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and latched mode bits.
package mipsfpga_spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/mipsfpga_spi_clkgen.sv
// Half-period tick generator: pulses tick_o every half_i enabled cycles.
module mipsfpga_spi_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] half_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && !restart_i &&
                  (cnt_q == half_i - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart_i || !enable_i || tick_o)
      cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mipsfpga_spi_master.sv
// SPI master: one frame per accept, all four modes, MSB/LSB first.
module mipsfpga_spi_master
  import mipsfpga_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              send,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  half_period,
  input  logic              sdi,
  output logic              sck,
  output logic              sdo,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DIV_W-1:0]  h_q, h_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              trail_q, trail_d;
  logic              sck_q, sck_d;
  logic              sdo_q, sdo_d;
  logic              done_q, done_d;
  logic              accept;
  logic              tick;

  function automatic logic [BW-1:0] idx(
    input logic          lsb,
    input logic [BW-1:0] b
  );
    return lsb ? b : LAST - b;
  endfunction

  assign accept = send && (state_q == S_IDLE);

  mipsfpga_spi_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .enable_i  (state_q != S_IDLE),
    .restart_i (accept),
    .half_i    (h_q),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    h_d     = h_q;
    tx_d    = tx_q;
    rsh_d   = rsh_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    trail_d = trail_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (send) begin
          state_d = S_LEAD;
          mode_d  = '{cpol: cpol, cpha: cpha,
                      lsb_first: lsb_first};
          h_d     = (half_period == '0) ? DIV_W'(1)
                                        : half_period;
          tx_d    = tx_data;
          rsh_d   = '0;
          bit_d   = '0;
          trail_d = 1'b0;
          sck_d   = cpol;
          if (!cpha)
            sdo_d = tx_data[idx(lsb_first, '0)];
        end
      end
      S_LEAD: begin
        if (tick) state_d = S_XFER;
      end
      S_XFER: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (!trail_q) begin
            trail_d = 1'b1;
            if (!mode_q.cpha)
              rsh_d[idx(mode_q.lsb_first, bit_q)] = sdi;
            else
              sdo_d = tx_q[idx(mode_q.lsb_first, bit_q)];
          end else begin
            trail_d = 1'b0;
            if (mode_q.cpha)
              rsh_d[idx(mode_q.lsb_first, bit_q)] = sdi;
            // last trailing edge: hold sdo, no wrap
            if (bit_q == LAST) begin
              state_d = S_TRAIL;
            end else begin
              bit_d = bit_q + BW'(1);
              if (!mode_q.cpha)
                sdo_d = tx_q[idx(mode_q.lsb_first,
                                 bit_q + BW'(1))];
            end
          end
        end
      end
      S_TRAIL: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          rx_d    = rsh_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      h_q     <= DIV_W'(1);
      tx_q    <= '0;
      rsh_q   <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      trail_q <= 1'b0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      h_q     <= h_d;
      tx_q    <= tx_d;
      rsh_q   <= rsh_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      trail_q <= trail_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
    end
  end

  assign sck     = sck_q;
  assign sdo     = sdo_q;
  assign cs_n    = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign rx_data = rx_q;

endmodule

// File: tb/tb_mipsfpga_spi_master.sv
// Directed bench for mipsfpga_spi_master (DATA_W=8).
module tb_mipsfpga_spi_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  tx_data;
  logic        send;
  logic        cpol, cpha, lsb_first;
  logic [15:0] half_period;
  logic        sdi;
  logic        sck, sdo, cs_n, busy, done;
  logic [7:0]  rx_data;

  logic        loop;
  logic        sdi_k;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  int          t0, fall_rel, done_rel, ndone, rises, sdo_nf;
  logic [7:0]  cap;

  assign sdi = loop ? sdo : sdi_k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mipsfpga_spi_master #(
    .DATA_W(8),
    .DIV_W (16)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .send        (send),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsb_first   (lsb_first),
    .half_period (half_period),
    .sdi         (sdi),
    .sck         (sck),
    .sdo         (sdo),
    .cs_n        (cs_n),
    .busy        (busy),
    .done        (done),
    .rx_data     (rx_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // one frame; inj>1 pulses send with 0xFF at that cycle offset
  task automatic run(input logic [7:0] tx, input logic pol,
                     input logic pha, input logic lsb,
                     input logic [15:0] h, input int inj);
    logic ps, psdo, pcs;
    @(negedge clk);
    tx_data = tx; cpol = pol; cpha = pha;
    lsb_first = lsb; half_period = h; send = 1'b1;
    t0 = cyc; fall_rel = -1; done_rel = -1;
    ndone = 0; rises = 0; sdo_nf = 0; cap = '0;
    ps = sck; psdo = sdo; pcs = cs_n;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      if (i == 1) send = 1'b0;
      if (inj > 1 && i == inj) begin
        send = 1'b1; tx_data = 8'hFF;
      end else if (inj > 1 && i == inj + 1) begin
        send = 1'b0; tx_data = tx;
      end
      if (pcs && !cs_n && fall_rel < 0) fall_rel = cyc - t0;
      if (sck != ps) begin
        if (sck) rises++;
        if (sck == !(pol ^ pha)) cap = {cap[6:0], sdo};
      end
      if (sdo != psdo && !(ps && !sck)) sdo_nf++;
      if (done) begin
        ndone++;
        if (done_rel < 0) done_rel = cyc - t0;
      end
      ps = sck; psdo = sdo; pcs = cs_n;
      if (done_rel >= 0 && cyc - t0 > done_rel + 3) break;
    end
  endtask

  initial begin
    int d1, d2, f2;
    logic pcs;
    resetn = 1'b0; send = 1'b1; tx_data = 8'h5A;
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
    half_period = 16'd1; loop = 1'b1; sdi_k = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sck",  32'(sck),     32'd0);
    chk("rst_sdo",  32'(sdo),     32'd0);
    chk("rst_csn",  32'(cs_n),    32'd1);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_done", 32'(done),    32'd0);
    chk("rst_rx",   32'(rx_data), 32'd0);
    resetn = 1'b1; send = 1'b0;
    repeat (2) @(negedge clk);

    // mode 0, loopback
    run(8'hA5, 1'b0, 1'b0, 1'b0, 16'd2, 0);
    chk("m0_csfall", 32'(fall_rel), 32'd1);
    chk("m0_rises",  32'(rises),    32'd8);
    chk("m0_done",   32'(done_rel), 32'd37);
    chk("m0_ndone",  32'(ndone),    32'd1);
    chk("m0_rx",     32'(rx_data),  32'h A5);
    chk("m0_sdo",    32'(cap),      32'h A5);
    chk("m0_idle",   32'(cs_n),     32'd1);

    // mode 3, sdi tied high
    loop = 1'b0; sdi_k = 1'b1;
    run(8'h3C, 1'b1, 1'b1, 1'b0, 16'd1, 0);
    chk("m3_done",   32'(done_rel), 32'd19);
    chk("m3_rx",     32'(rx_data),  32'h FF);
    chk("m3_sdo",    32'(cap),      32'h 3C);
    chk("m3_sdofall",32'(sdo_nf),   32'd0);
    chk("m3_sckidle",32'(sck),      32'd1);

    // lsb first, mode 0
    loop = 1'b1;
    run(8'h01, 1'b0, 1'b0, 1'b1, 16'd2, 0);
    chk("lsb_sdo",  32'(cap),      32'h 80);
    chk("lsb_rx",   32'(rx_data),  32'h 01);
    chk("lsb_done", 32'(done_rel), 32'd37);

    // send mid-frame is ignored
    run(8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 7);
    chk("ign_sdo",   32'(cap),     32'h 00);
    chk("ign_ndone", 32'(ndone),   32'd1);
    chk("ign_rx",    32'(rx_data), 32'h 00);

    // back-to-back with send held
    @(negedge clk);
    tx_data = 8'h5A; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; half_period = 16'd1; send = 1'b1;
    t0 = cyc; d1 = -1; d2 = -1; f2 = -1; pcs = cs_n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (d1 >= 0 && pcs && !cs_n && f2 < 0) f2 = cyc;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) begin d2 = cyc; send = 1'b0; end
      end
      pcs = cs_n;
      if (d2 >= 0 && cyc > d2 + 2) break;
    end
    chk("b2b_d1",   32'(d1 - t0), 32'd19);
    chk("b2b_fall", 32'(f2 - d1), 32'd1);
    chk("b2b_gap",  32'(d2 - d1), 32'd19);
    chk("b2b_rx",   32'(rx_data), 32'h 5A);
    send = 1'b0;

    // reset during bit 4 of XFER
    @(negedge clk);
    tx_data = 8'hA5; half_period = 16'd2; send = 1'b1;
    t0 = cyc;
    @(negedge clk);
    send = 1'b0;
    for (int i = 0; i < 50 && cyc < t0 + 20; i++)
      @(negedge clk);
    chk("rs_busy0", 32'(busy), 32'd1);
    resetn = 1'b0; send = 1'b1;
    @(negedge clk);
    chk("rs_csn",  32'(cs_n),    32'd1);
    chk("rs_sck",  32'(sck),     32'd0);
    chk("rs_busy", 32'(busy),    32'd0);
    chk("rs_done", 32'(done),    32'd0);
    chk("rs_rx",   32'(rx_data), 32'd0);
    @(negedge clk);
    resetn = 1'b1; send = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rs_quiet", 32'(ndone), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
